// File: rtl/sd_cmd_arbiter_if.sv
// Bundle of host/data requester handshakes and the command-master register
// interface seen by sd_cmd_arbiter.
interface sd_cmd_arbiter_if;
  // host requester
  logic        h_req;
  logic [31:0] h_arg;
  logic [13:0] h_cmd_set;
  logic        h_grant;
  logic        h_done;
  // data-path requester (auto CMD12/CMD13)
  logic        d_req;
  logic [31:0] d_arg;
  logic [13:0] d_cmd_set;
  logic        d_grant;
  logic        d_done;
  // command master side
  logic        new_cmd_o;
  logic [31:0] arg_o;
  logic [13:0] cmd_set_o;
  logic        cmd_busy_i;
  logic        cc_i;
  logic        ei_i;
  logic [4:0]  err_int_i;
  logic [31:0] resp_i;
  logic        int_rst_o;
  logic [31:0] resp_o;
  logic [5:0]  err_o;
  logic        owner_o;

  modport master (
    input  h_req, h_arg, h_cmd_set, d_req, d_arg, d_cmd_set,
    input  cmd_busy_i, cc_i, ei_i, err_int_i, resp_i,
    output h_grant, h_done, d_grant, d_done,
    output new_cmd_o, arg_o, cmd_set_o, int_rst_o, resp_o, err_o, owner_o
  );

  modport slave (
    output h_req, h_arg, h_cmd_set, d_req, d_arg, d_cmd_set,
    output cmd_busy_i, cc_i, ei_i, err_int_i, resp_i,
    input  h_grant, h_done, d_grant, d_done,
    input  new_cmd_o, arg_o, cmd_set_o, int_rst_o, resp_o, err_o, owner_o
  );
endinterface

// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter sharing one SD command master between the host and the
// data path; issues one command at a time and captures its completion status.
module sd_cmd_arbiter #(
  parameter logic [15:0] START_TMO  = 16'd255,
  parameter logic [3:0]  GAP_CYCLES = 4'd4
) (
  input  logic             CLK_PAD_IO,
  input  logic             RST_PAD_I,
  sd_cmd_arbiter_if.master bus
);

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_ISSUE     = 5'b00010,
    S_WAIT_DONE = 5'b00100,
    S_CLEAR     = 5'b01000,
    S_GAP       = 5'b10000
  } state_t;

  localparam logic OWNER_HOST = 1'b0;

  state_t      state_q;
  logic        pend_h_q;
  logic        pend_d_q;
  logic        last_owner_q;
  logic [15:0] start_cnt_q;
  logic [3:0]  gap_cnt_q;

  logic        h_grant_q;
  logic        h_done_q;
  logic        d_grant_q;
  logic        d_done_q;
  logic        new_cmd_q;
  logic [31:0] arg_q;
  logic [13:0] cmd_set_q;
  logic        int_rst_q;
  logic [31:0] resp_q;
  logic [5:0]  err_q;
  logic        owner_q;

  logic        pend_h_s;
  logic        pend_d_s;
  logic        grant_h_s;
  logic        grant_d_s;
  logic        pend_h_d;
  logic        pend_d_d;
  logic [15:0] start_cnt_inc_s;
  logic        start_tmo_s;
  logic [3:0]  gap_cnt_inc_s;
  logic        gap_end_s;
  logic        cmd_end_s;

  // Pending flags merged with same-cycle requests, then round-robin choice in IDLE
  always_comb begin
    pend_h_s  = pend_h_q | bus.h_req;
    pend_d_s  = pend_d_q | bus.d_req;
    grant_h_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_q == S_IDLE) begin
      if (pend_h_s && pend_d_s) begin
        if (last_owner_q == OWNER_HOST) begin
          grant_d_s = 1'b1;
        end else begin
          grant_h_s = 1'b1;
        end
      end else begin
        grant_h_s = pend_h_s;
        grant_d_s = pend_d_s;
      end
    end else begin
      grant_h_s = 1'b0;
      grant_d_s = 1'b0;
    end
    pend_h_d = pend_h_s & ~grant_h_s;
    pend_d_d = pend_d_s & ~grant_d_s;
  end

  // Counter end conditions; a zero GAP_CYCLES still spends one cycle in GAP
  always_comb begin
    start_cnt_inc_s = start_cnt_q + 16'd1;
    start_tmo_s     = (start_cnt_inc_s >= START_TMO);
    gap_cnt_inc_s   = gap_cnt_q + 4'd1;
    gap_end_s       = (gap_cnt_inc_s >= GAP_CYCLES);
    cmd_end_s       = bus.cc_i | bus.ei_i;
  end

  // Command sequencing FSM with all outputs registered
  always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
    if (RST_PAD_I) begin
      state_q      <= S_IDLE;
      pend_h_q     <= 1'b0;
      pend_d_q     <= 1'b0;
      last_owner_q <= OWNER_HOST;
      start_cnt_q  <= 16'd0;
      gap_cnt_q    <= 4'd0;
      h_grant_q    <= 1'b0;
      h_done_q     <= 1'b0;
      d_grant_q    <= 1'b0;
      d_done_q     <= 1'b0;
      new_cmd_q    <= 1'b0;
      arg_q        <= 32'd0;
      cmd_set_q    <= 14'd0;
      int_rst_q    <= 1'b0;
      resp_q       <= 32'd0;
      err_q        <= 6'd0;
      owner_q      <= 1'b0;
    end else begin
      pend_h_q  <= pend_h_d;
      pend_d_q  <= pend_d_d;
      h_grant_q <= 1'b0;
      d_grant_q <= 1'b0;
      h_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      int_rst_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_h_s || grant_d_s) begin
            h_grant_q    <= grant_h_s;
            d_grant_q    <= grant_d_s;
            owner_q      <= grant_d_s;
            last_owner_q <= grant_d_s;
            arg_q        <= grant_d_s ? bus.d_arg : bus.h_arg;
            cmd_set_q    <= grant_d_s ? bus.d_cmd_set : bus.h_cmd_set;
            start_cnt_q  <= 16'd0;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_cnt_q <= start_cnt_inc_s;
          if (bus.cmd_busy_i) begin
            new_cmd_q <= 1'b0;
            state_q   <= S_WAIT_DONE;
          end else if (start_tmo_s) begin
            // command master never picked the command up
            new_cmd_q <= 1'b0;
            err_q     <= 6'b100000;
            h_done_q  <= ~owner_q;
            d_done_q  <= owner_q;
            int_rst_q <= 1'b1;
            state_q   <= S_CLEAR;
          end else begin
            new_cmd_q <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (cmd_end_s) begin
            resp_q    <= bus.resp_i;
            err_q     <= {1'b0, bus.err_int_i};
            h_done_q  <= ~owner_q;
            d_done_q  <= owner_q;
            int_rst_q <= 1'b1;
            state_q   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          gap_cnt_q <= 4'd0;
          state_q   <= S_GAP;
        end
        S_GAP: begin
          if (gap_end_s) begin
            gap_cnt_q <= 4'd0;
            state_q   <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_inc_s;
          end
        end
        default: begin
          new_cmd_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.h_grant   = h_grant_q;
  assign bus.h_done    = h_done_q;
  assign bus.d_grant   = d_grant_q;
  assign bus.d_done    = d_done_q;
  assign bus.new_cmd_o = new_cmd_q;
  assign bus.arg_o     = arg_q;
  assign bus.cmd_set_o = cmd_set_q;
  assign bus.int_rst_o = int_rst_q;
  assign bus.resp_o    = resp_q;
  assign bus.err_o     = err_q;
  assign bus.owner_o   = owner_q;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Directed bench for sd_cmd_arbiter: host-only, tie arbitration, error,
// start timeout, duplicate request and mid-command reset scenarios.
module tb_sd_cmd_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sd_cmd_arbiter_if bus ();

  sd_cmd_arbiter #(
    .START_TMO  (16'd255),
    .GAP_CYCLES (4'd4)
  ) dut (
    .CLK_PAD_IO (clk),
    .RST_PAD_I  (rst),
    .bus        (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // After a grant: ISSUE, busy seen, completion with response rsp
  task automatic run_cmd(input string tag, input logic own_d, input logic [31:0] rsp);
    tick();
    chk({tag, "_new_cmd_hi"}, {31'd0, bus.new_cmd_o}, 32'd1);
    bus.cmd_busy_i = 1'b1;
    tick();
    chk({tag, "_new_cmd_lo"}, {31'd0, bus.new_cmd_o}, 32'd0);
    bus.cc_i   = 1'b1;
    bus.resp_i = rsp;
    tick();
    bus.cc_i       = 1'b0;
    bus.cmd_busy_i = 1'b0;
    chk({tag, "_h_done"}, {31'd0, bus.h_done}, {31'd0, ~own_d});
    chk({tag, "_d_done"}, {31'd0, bus.d_done}, {31'd0, own_d});
    chk({tag, "_resp"}, bus.resp_o, rsp);
    chk({tag, "_int_rst"}, {31'd0, bus.int_rst_o}, 32'd1);
  endtask

  // From the done cycle: CLEAR + 4 GAP cycles brings the FSM back to IDLE
  task automatic finish_to_idle();
    repeat (5) tick();
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    bus.h_req      = 1'b0;
    bus.h_arg      = 32'd0;
    bus.h_cmd_set  = 14'd0;
    bus.d_req      = 1'b0;
    bus.d_arg      = 32'd0;
    bus.d_cmd_set  = 14'd0;
    bus.cmd_busy_i = 1'b0;
    bus.cc_i       = 1'b0;
    bus.ei_i       = 1'b0;
    bus.err_int_i  = 5'd0;
    bus.resp_i     = 32'd0;

    // reset state
    tick();
    chk("rst_new_cmd", {31'd0, bus.new_cmd_o}, 32'd0);
    chk("rst_grants", {30'd0, bus.h_grant, bus.d_grant}, 32'd0);
    chk("rst_int_rst", {31'd0, bus.int_rst_o}, 32'd0);
    chk("rst_err", {26'd0, bus.err_o}, 32'd0);
    rst = 1'b0;
    tick();

    // host-only command
    bus.h_arg     = 32'h0000_01AA;
    bus.h_cmd_set = 14'h0802;
    bus.h_req     = 1'b1;
    tick();
    bus.h_req = 1'b0;
    chk("host_grant", {31'd0, bus.h_grant}, 32'd1);
    chk("host_new_cmd_lat", {31'd0, bus.new_cmd_o}, 32'd0);
    chk("host_arg", bus.arg_o, 32'h0000_01AA);
    chk("host_cmd_set", {18'd0, bus.cmd_set_o}, 32'h0000_0802);
    chk("host_owner", {31'd0, bus.owner_o}, 32'd0);
    tick();
    chk("host_grant_pulse", {31'd0, bus.h_grant}, 32'd0);
    chk("host_new_cmd", {31'd0, bus.new_cmd_o}, 32'd1);
    tick();
    tick();
    chk("host_new_cmd_held", {31'd0, bus.new_cmd_o}, 32'd1);
    bus.cmd_busy_i = 1'b1;
    tick();
    chk("host_new_cmd_drop", {31'd0, bus.new_cmd_o}, 32'd0);
    repeat (19) tick();
    chk("host_no_early_done", {31'd0, bus.h_done}, 32'd0);
    bus.cc_i   = 1'b1;
    bus.resp_i = 32'h0000_01AA;
    tick();
    bus.cc_i       = 1'b0;
    bus.cmd_busy_i = 1'b0;
    chk("host_done", {31'd0, bus.h_done}, 32'd1);
    chk("host_resp", bus.resp_o, 32'h0000_01AA);
    chk("host_err", {26'd0, bus.err_o}, 32'd0);
    chk("host_int_rst", {31'd0, bus.int_rst_o}, 32'd1);
    tick();
    chk("host_done_pulse", {31'd0, bus.h_done}, 32'd0);
    chk("host_int_rst_pulse", {31'd0, bus.int_rst_o}, 32'd0);
    repeat (4) tick();

    // simultaneous requests: data first, host after CLEAR + GAP
    bus.h_arg     = 32'h1111_0000;
    bus.h_cmd_set = 14'h0D00;
    bus.d_arg     = 32'h2222_0000;
    bus.d_cmd_set = 14'h0C03;
    bus.h_req     = 1'b1;
    bus.d_req     = 1'b1;
    tick();
    bus.h_req = 1'b0;
    bus.d_req = 1'b0;
    chk("tie1_d_grant", {31'd0, bus.d_grant}, 32'd1);
    chk("tie1_h_grant", {31'd0, bus.h_grant}, 32'd0);
    chk("tie1_owner", {31'd0, bus.owner_o}, 32'd1);
    chk("tie1_arg", bus.arg_o, 32'h2222_0000);
    chk("tie1_cmd_set", {18'd0, bus.cmd_set_o}, 32'h0000_0C03);
    run_cmd("tie1_d", 1'b1, 32'h0000_0900);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("tie1_h_wait", {31'd0, bus.h_grant}, 32'd0);
    end
    tick();
    chk("tie1_h_grant_late", {31'd0, bus.h_grant}, 32'd1);
    chk("tie1_h_arg", bus.arg_o, 32'h1111_0000);
    chk("tie1_h_owner", {31'd0, bus.owner_o}, 32'd0);
    run_cmd("tie1_h", 1'b0, 32'h0000_0B00);
    finish_to_idle();

    // error interrupt completion
    bus.h_req = 1'b1;
    tick();
    bus.h_req = 1'b0;
    chk("err_grant", {31'd0, bus.h_grant}, 32'd1);
    tick();
    bus.cmd_busy_i = 1'b1;
    tick();
    bus.ei_i      = 1'b1;
    bus.err_int_i = 5'b00011;
    bus.resp_i    = 32'hDEAD_BEEF;
    tick();
    bus.ei_i       = 1'b0;
    bus.err_int_i  = 5'd0;
    bus.cmd_busy_i = 1'b0;
    bus.resp_i     = 32'd0;
    chk("err_done", {31'd0, bus.h_done}, 32'd1);
    chk("err_bits", {26'd0, bus.err_o}, 32'h0000_0003);
    chk("err_resp", bus.resp_o, 32'hDEAD_BEEF);
    finish_to_idle();
    chk("err_bits_held", {26'd0, bus.err_o}, 32'h0000_0003);
    chk("err_resp_held", bus.resp_o, 32'hDEAD_BEEF);

    // start timeout: command master never goes busy
    bus.h_req = 1'b1;
    tick();
    bus.h_req = 1'b0;
    chk("tmo_grant", {31'd0, bus.h_grant}, 32'd1);
    repeat (254) tick();
    chk("tmo_new_cmd_still", {31'd0, bus.new_cmd_o}, 32'd1);
    chk("tmo_no_early_done", {31'd0, bus.h_done}, 32'd0);
    tick();
    chk("tmo_done", {31'd0, bus.h_done}, 32'd1);
    chk("tmo_err", {26'd0, bus.err_o}, 32'h0000_0020);
    chk("tmo_new_cmd_drop", {31'd0, bus.new_cmd_o}, 32'd0);
    chk("tmo_int_rst", {31'd0, bus.int_rst_o}, 32'd1);
    chk("tmo_resp_held", bus.resp_o, 32'hDEAD_BEEF);

    // repeated d_req while pending during CLEAR/GAP: one data command only
    tick();
    bus.d_req = 1'b1;
    tick();
    bus.d_req = 1'b0;
    tick();
    bus.d_req = 1'b1;
    tick();
    bus.d_req = 1'b0;
    tick();
    tick();
    chk("dup_d_grant", {31'd0, bus.d_grant}, 32'd1);
    chk("dup_d_arg", bus.arg_o, 32'h2222_0000);
    run_cmd("dup_d", 1'b1, 32'h0000_0D00);
    chk("dup_err_cleared", {26'd0, bus.err_o}, 32'd0);
    finish_to_idle();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("dup_no_second", {30'd0, bus.h_grant, bus.d_grant}, 32'd0);
    end

    // tie after a data command goes to host
    bus.h_req = 1'b1;
    bus.d_req = 1'b1;
    tick();
    bus.h_req = 1'b0;
    bus.d_req = 1'b0;
    chk("tie2_h_grant", {31'd0, bus.h_grant}, 32'd1);
    chk("tie2_d_grant", {31'd0, bus.d_grant}, 32'd0);
    run_cmd("tie2_h", 1'b0, 32'h0000_0E00);
    finish_to_idle();
    tick();
    chk("tie2_d_after", {31'd0, bus.d_grant}, 32'd1);

    // reset in WAIT_DONE with a data request pending
    tick();
    bus.cmd_busy_i = 1'b1;
    tick();
    bus.d_req = 1'b1;
    tick();
    bus.d_req = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_new_cmd", {31'd0, bus.new_cmd_o}, 32'd0);
    chk("mid_rst_owner", {31'd0, bus.owner_o}, 32'd0);
    chk("mid_rst_arg", bus.arg_o, 32'd0);
    chk("mid_rst_resp", bus.resp_o, 32'd0);
    chk("mid_rst_err", {26'd0, bus.err_o}, 32'd0);
    chk("mid_rst_int_rst", {31'd0, bus.int_rst_o}, 32'd0);
    bus.cmd_busy_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_grant", {30'd0, bus.h_grant, bus.d_grant}, 32'd0);
      chk("post_rst_no_int_rst", {31'd0, bus.int_rst_o}, 32'd0);
    end
    bus.h_req = 1'b1;
    bus.d_req = 1'b1;
    tick();
    bus.h_req = 1'b0;
    bus.d_req = 1'b0;
    chk("post_rst_tie_data", {30'd0, bus.h_grant, bus.d_grant}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_cmd_arbiter.md
SD_CMD_ARBITER -- requirements
Module: sd_cmd_arbiter

Interface
REQ-001 Parameter START_TMO, default 16'd255: maximum cycles in ISSUE waiting for the command master to accept a command.
REQ-002 Parameter GAP_CYCLES, default 4'd4: idle cycles inserted between consecutive commands.
REQ-003 One clock; reset is asynchronous and active-high. The ports are CLK_PAD_IO (clock) and RST_PAD_I (reset).
REQ-004 CLK_PAD_IO  in  1  system clock.
REQ-005 RST_PAD_I  in  1  asynchronous active-high reset.
REQ-006 h_req  in  1  host request pulse (one cycle).
REQ-007 h_arg  in  32  host argument; held stable while the host request is pending.
REQ-008 h_cmd_set  in  14  host command-set word (index[13:8], word select[7:6], CICE[4], CRCE[3], RTS[1:0]).
REQ-009 h_grant  out  1  host command selected (one-cycle pulse).
REQ-010 h_done  out  1  host command finished (one-cycle pulse).
REQ-011 d_req, d_arg[31:0], d_cmd_set[13:0], d_grant, d_done: same as REQ-006..010, for the data-path requester (auto CMD12/CMD13).
REQ-012 new_cmd_o  out  1  New_CMD to the command master.
REQ-013 arg_o  out  32  ARG_REG to the command master.
REQ-014 cmd_set_o  out  14  CMD_SET_REG to the command master.
REQ-015 cmd_busy_i  in  1  command-master STATUS_REG[0] (command in progress).
REQ-016 cc_i  in  1  NORMAL_INT_REG[0] (command complete).
REQ-017 ei_i  in  1  NORMAL_INT_REG[15] (error interrupt).
REQ-018 err_int_i  in  5  ERR_INT_REG.
REQ-019 resp_i  in  32  RESP_1_REG.
REQ-020 int_rst_o  out  1  drives both ERR_INT_RST and NORMAL_INT_RST.
REQ-021 resp_o  out  32  captured response of the last finished command.
REQ-022 err_o  out  6  [4:0] captured err_int_i; [5] start timeout.
REQ-023 owner_o  out  1  owner of the current or last command: 0 = host, 1 = data.

Function
REQ-024 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE, CLEAR, GAP, and SHALL be one-hot encoded.
REQ-025 Pending flags: h_req/d_req set pend_h/pend_d; a flag clears in the cycle its grant pulses; a req arriving while its flag is already set is ignored (no queueing beyond one).
REQ-026 IDLE, no pending request: stay in IDLE.
REQ-027 IDLE, one request pending: grant that requester (one-cycle grant pulse), set owner_o, latch arg_o/cmd_set_o from that requester, move to ISSUE.
REQ-028 IDLE, both pending: grant the requester not equal to last_owner (round-robin); last_owner resets to host, so data wins the first tie.
REQ-029 A req arriving in the same cycle as the IDLE decision SHALL take part in arbitration (set and sample in one cycle).
REQ-030 ISSUE: new_cmd_o=1 each cycle and a 16-bit start counter increments.
REQ-031 ISSUE -> WAIT_DONE when cmd_busy_i=1: new_cmd_o drops in the cycle after cmd_busy_i is sampled high.
REQ-032 ISSUE -> CLEAR when the start counter reaches START_TMO: set err_o[5]=1, clear err_o[4:0], pulse the owner's done.
REQ-033 WAIT_DONE: on cc_i|ei_i, in one cycle, capture resp_i into resp_o and err_int_i into err_o[4:0], clear err_o[5], pulse the owner's done, move to CLEAR.
REQ-034 If cc_i and ei_i are both high, this SHALL be treated as one completion with error bits captured.
REQ-035 WAIT_DONE has no timeout; the command master's TIMEOUT_REG watchdog provides it.
REQ-036 CLEAR: int_rst_o=1 for exactly one cycle, then move to GAP.
REQ-037 GAP: a 4-bit counter runs for GAP_CYCLES cycles, then moves to IDLE; with GAP_CYCLES=0, GAP lasts one cycle.
REQ-038 New requests SHALL be accepted into the pending flags in every state.
REQ-039 resp_o and err_o SHALL hold their values until the next completion.
REQ-040 Grant-to-new_cmd_o latency SHALL be 1 cycle; completion-to-done latency SHALL be 1 cycle (registered).
REQ-041 All outputs SHALL be registered.

Reset
REQ-042 On RST_PAD_I=1, at any time including mid-command: state=IDLE; all outputs 0; pend_h=pend_d=0; last_owner=host; counters 0.
REQ-043 Reset SHALL NOT issue int_rst_o; the command master is reset by the same signal.

Verification
REQ-044 Host-only: h_req, cmd_set=14'h0802, arg=32'h1AA; cmd_busy_i high 3 cycles after new_cmd_o, cc_i 20 cycles later with resp_i=32'h1AA -> h_grant 1 pulse, new_cmd_o until busy seen, h_done 1 pulse, resp_o=32'h1AA, err_o=0, int_rst_o 1 pulse.
REQ-045 Simultaneous h_req and d_req after reset -> data granted first, host granted after CLEAR + 4 GAP cycles; the next tie goes to host.
REQ-046 cmd_busy_i never asserted, START_TMO=255 -> after 255 ISSUE cycles the owner's done pulses, err_o=6'b100000, FSM returns to IDLE via CLEAR/GAP.
REQ-047 ei_i with err_int_i=5'b00011 (CTE|CCRCE) -> done pulses, err_o=6'b000011, resp_o updated.
REQ-048 RST_PAD_I asserted in WAIT_DONE with pend_d=1 -> all outputs 0 immediately, pending cleared; no grant after reset release without a new req.
REQ-049 d_req repeated while pend_d=1 -> exactly one data command issued.
